// File: rtl/fitness_pkg.sv
// Shared types and default widths for the fitness accumulation stages.
package fitness_pkg;

  localparam int unsigned DIN_WIDTH_DEF = 32;
  localparam int unsigned ACC_WIDTH_DEF = 48;
  localparam int unsigned CNT_WIDTH_DEF = 16;

  // Saturation limits of the default-width signed accumulator.
  localparam logic [ACC_WIDTH_DEF-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH_DEF-1){1'b1}}};
  localparam logic [ACC_WIDTH_DEF-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH_DEF-1){1'b0}}};

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    FOLD  = 2'd1,
    EMIT  = 2'd2
  } fit_state_e;

endpackage

// File: rtl/fitness_abs_sat.sv
// Combinational magnitude of a signed value; the most negative input clamps
// to the largest positive value and raises sat_c.
module fitness_abs_sat #(
  parameter int unsigned W = 48
) (
  input  logic [W-1:0] x_i,
  output logic [W-1:0] abs_c,
  output logic         sat_c
);

  localparam logic [W-1:0] POS_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] NEG_MIN = {1'b1, {(W-1){1'b0}}};

  always_comb begin
    sat_c = (x_i == NEG_MIN);
    abs_c = x_i;
    if (sat_c) begin
      abs_c = POS_MAX;
    end else if (x_i[W-1]) begin
      abs_c = W'(-x_i);
    end
  end

endmodule

// File: rtl/fitness_accumulator.sv
// Per-dimension signed accumulation of products, folding |sum| into a running
// maximum and emitting that maximum as the solution fitness.
module fitness_accumulator
  import fitness_pkg::*;
#(
  parameter int unsigned DIN_WIDTH = DIN_WIDTH_DEF,
  parameter int unsigned ACC_WIDTH = ACC_WIDTH_DEF,
  parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic                 prod_tvalid,
  output logic                 prod_tready,
  input  logic [DIN_WIDTH-1:0] prod_tdata,
  input  logic                 prod_tlast_dim,
  input  logic                 prod_tlast,
  output logic                 fit_tvalid,
  input  logic                 fit_tready,
  output logic [ACC_WIDTH-1:0] fit_tdata,
  output logic [CNT_WIDTH-1:0] fit_dims,
  output logic                 fit_ovf
);

  localparam int unsigned SUM_W = ACC_WIDTH + 1;
  localparam logic [ACC_WIDTH-1:0] ACC_MAX_W = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN_W = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic [CNT_WIDTH-1:0] CNT_ALL1  = {CNT_WIDTH{1'b1}};

  fit_state_e state_q, state_d;

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] max_q, max_d;
  logic [CNT_WIDTH-1:0] dim_cnt_q, dim_cnt_d;
  logic                 ovf_q, ovf_d;
  logic [ACC_WIDTH-1:0] fit_tdata_q, fit_tdata_d;
  logic [CNT_WIDTH-1:0] fit_dims_q, fit_dims_d;
  logic                 fit_ovf_q, fit_ovf_d;
  logic                 fit_tvalid_q, fit_tvalid_d;
  logic                 prod_tready_q, prod_tready_d;

  logic                 beat_c;
  logic [SUM_W-1:0]     sum_c;
  logic                 sum_ovf_c;
  logic [ACC_WIDTH-1:0] acc_sat_c;
  logic [ACC_WIDTH-1:0] abs_c;
  logic                 abs_sat_c;

  assign beat_c = prod_tvalid & prod_tready_q;

  // One extra bit of headroom exposes signed overflow as a mismatch of the top two bits.
  assign sum_c = {acc_q[ACC_WIDTH-1], acc_q}
               + {{(SUM_W-DIN_WIDTH){prod_tdata[DIN_WIDTH-1]}}, prod_tdata};
  assign sum_ovf_c = sum_c[SUM_W-1] ^ sum_c[SUM_W-2];
  assign acc_sat_c = sum_ovf_c ? (sum_c[SUM_W-1] ? ACC_MIN_W : ACC_MAX_W)
                               : sum_c[ACC_WIDTH-1:0];

  fitness_abs_sat #(
    .W (ACC_WIDTH)
  ) u_abs_sat (
    .x_i   (acc_sat_c),
    .abs_c (abs_c),
    .sat_c (abs_sat_c)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    max_d       = max_q;
    dim_cnt_d   = dim_cnt_q;
    ovf_d       = ovf_q;
    fit_tdata_d = fit_tdata_q;
    fit_dims_d  = fit_dims_q;
    fit_ovf_d   = fit_ovf_q;

    unique case (state_q)
      ACCUM: begin
        if (beat_c) begin
          acc_d = acc_sat_c;
          if (sum_ovf_c) begin
            ovf_d = 1'b1;
          end
          if (prod_tlast_dim || prod_tlast) begin
            acc_d = '0;
            if (abs_c > max_q) begin
              max_d = abs_c;
            end
            if (abs_sat_c) begin
              ovf_d = 1'b1;
            end
            if (dim_cnt_q != CNT_ALL1) begin
              dim_cnt_d = dim_cnt_q + CNT_WIDTH'(1);
            end
            if (prod_tlast) begin
              state_d = FOLD;
            end
          end
        end
      end
      FOLD: begin
        fit_tdata_d = max_q;
        fit_dims_d  = dim_cnt_q;
        fit_ovf_d   = ovf_q;
        max_d       = '0;
        dim_cnt_d   = '0;
        ovf_d       = 1'b0;
        state_d     = EMIT;
      end
      EMIT: begin
        if (fit_tvalid_q && fit_tready) begin
          state_d = ACCUM;
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase

    prod_tready_d = (state_d == ACCUM);
    fit_tvalid_d  = (state_d == EMIT);
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q       <= ACCUM;
      acc_q         <= '0;
      max_q         <= '0;
      dim_cnt_q     <= '0;
      ovf_q         <= 1'b0;
      fit_tdata_q   <= '0;
      fit_dims_q    <= '0;
      fit_ovf_q     <= 1'b0;
      fit_tvalid_q  <= 1'b0;
      prod_tready_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      max_q         <= max_d;
      dim_cnt_q     <= dim_cnt_d;
      ovf_q         <= ovf_d;
      fit_tdata_q   <= fit_tdata_d;
      fit_dims_q    <= fit_dims_d;
      fit_ovf_q     <= fit_ovf_d;
      fit_tvalid_q  <= fit_tvalid_d;
      prod_tready_q <= prod_tready_d;
    end
  end

  assign prod_tready = prod_tready_q;
  assign fit_tvalid  = fit_tvalid_q;
  assign fit_tdata   = fit_tdata_q;
  assign fit_dims    = fit_dims_q;
  assign fit_ovf     = fit_ovf_q;

endmodule

// File: tb/tb_fitness_accumulator.sv
// Randomised scoreboard bench for fitness_accumulator, using a 33-bit
// accumulator so saturation is reachable with 32-bit products.
module tb_fitness_accumulator;

  localparam int unsigned DIN_W = 32;
  localparam int unsigned ACC_W = 33;
  localparam int unsigned CNT_W = 16;
  localparam longint AMAX = (64'sd1 <<< (ACC_W - 1)) - 64'sd1;
  localparam longint AMIN = -(64'sd1 <<< (ACC_W - 1));

  logic             ap_clk = 1'b0;
  logic             ap_rst_n = 1'b0;
  logic             prod_tvalid = 1'b0;
  logic             prod_tready;
  logic [DIN_W-1:0] prod_tdata = '0;
  logic             prod_tlast_dim = 1'b0;
  logic             prod_tlast = 1'b0;
  logic             fit_tvalid;
  logic             fit_tready = 1'b0;
  logic [ACC_W-1:0] fit_tdata;
  logic [CNT_W-1:0] fit_dims;
  logic             fit_ovf;

  fitness_accumulator #(
    .DIN_WIDTH (DIN_W),
    .ACC_WIDTH (ACC_W),
    .CNT_WIDTH (CNT_W)
  ) dut (
    .ap_clk         (ap_clk),
    .ap_rst_n       (ap_rst_n),
    .prod_tvalid    (prod_tvalid),
    .prod_tready    (prod_tready),
    .prod_tdata     (prod_tdata),
    .prod_tlast_dim (prod_tlast_dim),
    .prod_tlast     (prod_tlast),
    .fit_tvalid     (fit_tvalid),
    .fit_tready     (fit_tready),
    .fit_tdata      (fit_tdata),
    .fit_dims       (fit_dims),
    .fit_ovf        (fit_ovf)
  );

  always #5 ap_clk = ~ap_clk;

  int cyc = 0;
  always @(posedge ap_clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  typedef struct {
    longint data;
    int     dims;
    bit     ovf;
    int     rise;
  } exp_t;

  exp_t exp_q[$];

  // Reference: running sums with clamping, magnitude max per solution.
  longint m_acc = 0;
  longint m_max = 0;
  int     m_dims = 0;
  bit     m_ovf = 1'b0;

  task automatic model_clear();
    m_acc = 0; m_max = 0; m_dims = 0; m_ovf = 1'b0;
  endtask

  task automatic model_beat(input logic [DIN_W-1:0] d, input bit ld, input bit l, input int c);
    longint a;
    exp_t   e;
    m_acc = m_acc + longint'($signed(d));
    if (m_acc > AMAX) begin m_acc = AMAX; m_ovf = 1'b1; end
    if (m_acc < AMIN) begin m_acc = AMIN; m_ovf = 1'b1; end
    if (ld || l) begin
      a = (m_acc < 0) ? -m_acc : m_acc;
      if (a > AMAX) begin a = AMAX; m_ovf = 1'b1; end
      if (a > m_max) m_max = a;
      if (m_dims < 65535) m_dims++;
      m_acc = 0;
    end
    if (l) begin
      e.data = m_max; e.dims = m_dims; e.ovf = m_ovf; e.rise = c + 2;
      exp_q.push_back(e);
      model_clear();
    end
  endtask

  // fit_tready policy: 0 random, 1 held low, 2 held high.
  int rdy_mode = 2;
  always @(posedge ap_clk) begin
    #2;
    case (rdy_mode)
      0:       fit_tready = ($urandom_range(0, 2) != 0);
      1:       fit_tready = 1'b0;
      default: fit_tready = 1'b1;
    endcase
  end

  // Monitor: compares each presented result against the scoreboard head.
  bit           prev_v = 1'b0;
  bit           chk_rdy = 1'b0;
  logic [ACC_W-1:0] hold_d;
  logic [CNT_W-1:0] hold_n;
  logic         hold_o;
  exp_t         me;

  always @(negedge ap_clk) begin
    if (!ap_rst_n) begin
      prev_v  = 1'b0;
      chk_rdy = 1'b0;
    end else begin
      if (chk_rdy) begin
        chk("prod_tready_after_handshake", longint'(prod_tready), 1);
        chk_rdy = 1'b0;
      end
      if (fit_tvalid) begin
        chk("prod_tready_during_emit", longint'(prod_tready), 0);
        if (!prev_v) begin
          if (exp_q.size() == 0) chk("spurious_result", 1, 0);
          else chk("result_latency", longint'(cyc), longint'(exp_q[0].rise));
          hold_d = fit_tdata; hold_n = fit_dims; hold_o = fit_ovf;
        end else begin
          chk("hold_tdata", longint'(fit_tdata), longint'(hold_d));
          chk("hold_dims", longint'(fit_dims), longint'(hold_n));
          chk("hold_ovf", longint'(fit_ovf), longint'(hold_o));
        end
        if (fit_tready) begin
          if (exp_q.size() > 0) begin
            me = exp_q.pop_front();
            chk("fit_tdata", longint'(fit_tdata), me.data);
            chk("fit_dims", longint'(fit_dims), longint'(me.dims));
            chk("fit_ovf", longint'(fit_ovf), longint'(me.ovf));
          end
          chk_rdy = 1'b1;
          prev_v  = 1'b0;
        end else begin
          prev_v = 1'b1;
        end
      end else begin
        prev_v = 1'b0;
      end
    end
  end

  task automatic send_beat(input logic [DIN_W-1:0] d, input bit ld, input bit l);
    int w = 0;
    int c;
    @(negedge ap_clk);
    prod_tvalid = 1'b1; prod_tdata = d; prod_tlast_dim = ld; prod_tlast = l;
    while (!prod_tready && w < 300) begin
      @(negedge ap_clk);
      w++;
    end
    if (w >= 300) begin
      chk("beat_accept_timeout", 0, 1);
    end else begin
      c = cyc;
      @(posedge ap_clk);
      model_beat(d, ld, l, c);
    end
    #1;
    prod_tvalid = 1'b0; prod_tdata = $urandom; prod_tlast_dim = $urandom_range(0, 1);
    prod_tlast = $urandom_range(0, 1);
  endtask

  task automatic drain();
    int w = 0;
    while ((exp_q.size() != 0 || fit_tvalid) && w < 1000) begin
      @(negedge ap_clk);
      w++;
    end
    if (w >= 1000) chk("drain_timeout", longint'(exp_q.size()), 0);
  endtask

  function automatic logic [DIN_W-1:0] rand_data();
    logic [DIN_W-1:0] d;
    case ($urandom_range(0, 5))
      0, 1, 2: d = DIN_W'($urandom_range(0, 2000)) - DIN_W'(1000);
      3:       d = 32'h7FFF_FFFF;
      4:       d = 32'h8000_0000;
      default: d = $urandom;
    endcase
    return d;
  endfunction

  initial begin
    int w;
    // Reset values.
    repeat (3) @(negedge ap_clk);
    chk("reset_prod_tready", longint'(prod_tready), 0);
    chk("reset_fit_tvalid", longint'(fit_tvalid), 0);
    chk("reset_fit_tdata", longint'(fit_tdata), 0);
    chk("reset_fit_dims", longint'(fit_dims), 0);
    chk("reset_fit_ovf", longint'(fit_ovf), 0);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    chk("ready_after_reset", longint'(prod_tready), 1);

    // Single dimension: 5, -3, 7.
    send_beat(32'd5, 1'b0, 1'b0);
    send_beat(-32'sd3, 1'b0, 1'b0);
    send_beat(32'd7, 1'b0, 1'b1);
    drain();

    // Two dimensions: {10,-4}, {-20,3}.
    send_beat(32'd10, 1'b0, 1'b0);
    send_beat(-32'sd4, 1'b1, 1'b0);
    send_beat(-32'sd20, 1'b0, 1'b0);
    send_beat(32'd3, 1'b0, 1'b1);
    drain();

    // Backpressure in EMIT with an offered beat that must not be consumed.
    rdy_mode = 1;
    send_beat(32'd42, 1'b1, 1'b1);
    w = 0;
    while (!fit_tvalid && w < 20) begin @(negedge ap_clk); w++; end
    chk("emit_reached", longint'(fit_tvalid), 1);
    prod_tvalid = 1'b1; prod_tdata = 32'd123; prod_tlast = 1'b1; prod_tlast_dim = 1'b1;
    repeat (5) @(negedge ap_clk);
    prod_tvalid = 1'b0;
    rdy_mode = 2;
    drain();

    // Positive and negative saturation, then a clean solution.
    repeat (2) send_beat(32'h7FFF_FFFF, 1'b0, 1'b0);
    send_beat(32'h7FFF_FFFF, 1'b0, 1'b1);
    send_beat(32'd1, 1'b0, 1'b1);
    repeat (2) send_beat(32'h8000_0000, 1'b0, 1'b0);
    send_beat(32'h8000_0000, 1'b1, 1'b1);
    drain();

    // Reset mid-solution discards the partial result.
    send_beat(32'd100, 1'b0, 1'b0);
    send_beat(32'd200, 1'b1, 1'b0);
    @(negedge ap_clk);
    ap_rst_n = 1'b0;
    model_clear();
    @(negedge ap_clk);
    chk("midreset_prod_tready", longint'(prod_tready), 0);
    chk("midreset_fit_tvalid", longint'(fit_tvalid), 0);
    ap_rst_n = 1'b1;
    send_beat(32'd4, 1'b0, 1'b1);
    drain();

    // Randomised solutions with random gaps and backpressure.
    rdy_mode = 0;
    for (int s = 0; s < 40; s++) begin
      int nd;
      nd = $urandom_range(1, 4);
      for (int d = 0; d < nd; d++) begin
        int nb;
        nb = $urandom_range(1, 5);
        for (int b = 0; b < nb; b++) begin
          bit last_b;
          last_b = (b == nb - 1);
          if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge ap_clk);
          send_beat(rand_data(), last_b && ($urandom_range(0, 1) == 1 || d != nd - 1),
                    last_b && (d == nd - 1));
        end
      end
    end
    drain();

    repeat (3) @(negedge ap_clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fitness_accumulator.md
Name: fitness_accumulator

Overview:
Downstream consumer of the fitness kernel's 32x32 signed multiplier. It streams signed products (weight x partition sign, ±1) and accumulates one running sum per dimension. At each dimension boundary it folds |sum| into a running maximum. At end of solution it emits that maximum as the MDTWNPP fitness (smaller is better) over a valid/ready handshake.

Parameters:
DIN_WIDTH, 32, width of signed product input
ACC_WIDTH, 48, width of signed accumulator and of the unsigned fitness output
CNT_WIDTH, 16, width of the dimension counter reported with each result

Ports:
ap_clk  in  1  clock, all logic rising-edge
ap_rst_n  in  1  asynchronous active-low reset
prod_tvalid  in  1  product beat valid
prod_tready  out  1  accumulator can accept a beat
prod_tdata  in  DIN_WIDTH  signed product
prod_tlast_dim  in  1  beat is last item of current dimension
prod_tlast  in  1  beat is last item of whole solution (implies end of dimension)
fit_tvalid  out  1  fitness result valid
fit_tready  in  1  downstream accepts result
fit_tdata  out  ACC_WIDTH  max over dimensions of |sum|, unsigned
fit_dims  out  CNT_WIDTH  number of dimensions folded into this result
fit_ovf  out  1  sticky: accumulator saturated at least once in this solution

Behaviour:
- Reset (async assert, sync release) -> state ACCUM, acc=0, max=0, dim_cnt=0, ovf=0.
- Reset outputs: prod_tready=0 while ap_rst_n low, then 1 in ACCUM; fit_tvalid=0; fit_tdata=0; fit_dims=0; fit_ovf=0.
- Reset mid-solution discards all partial state; no result is emitted for that solution.
- Beat accepted when prod_tvalid & prod_tready.
- prod_tready = 1 only in ACCUM.
- States:
  - ACCUM: on each accepted beat, acc_next = acc + sext(prod_tdata), computed at ACC_WIDTH+1.
    - Signed overflow of acc_next saturates to +max/-min of ACC_WIDTH and sets ovf.
    - If tlast_dim or tlast: fold abs_sat(acc_next) into max (max = larger), dim_cnt+1 (saturating at all-ones), acc cleared to 0 in the same cycle.
    - If tlast: go to FOLD.
  - FOLD: one cycle; register fit_tdata=max, fit_dims=dim_cnt, fit_ovf=ovf; clear max/dim_cnt/ovf; go to EMIT.
  - EMIT: fit_tvalid=1, outputs held stable until fit_tready. On handshake: fit_tvalid=0 next cycle, go to ACCUM.
- Latency:
  - tlast beat accepted at cycle N -> fit_tvalid high at N+2.
  - Earliest next input accept: cycle after output handshake.
  - Minimum back-to-back solution gap: 2 dead input cycles.
- abs_sat: |x| for x > min; for x = -2^(ACC_WIDTH-1), result is 2^(ACC_WIDTH-1)-1 and ovf is set.
- tlast_dim and tlast together on one beat: treated as a single dimension end (dim_cnt+1 only once).
- A single-beat solution (first beat has tlast) is legal; dims=1.
- fit_tready may be high before fit_tvalid; handshake completes in the first EMIT cycle.
- prod_tdata and flags are ignored when the beat is not accepted.

Decomposition:
- Package fitness_pkg:
  - DIN_WIDTH/ACC_WIDTH/CNT_WIDTH defaults
  - state enum {ACCUM, FOLD, EMIT}
  - ACC_MAX/ACC_MIN constants
- Sub-module fitness_abs_sat: combinational |x| with saturation flag; it is reused by other fitness stages.

Test Plan:
1. Products 5,-3,7 (tlast on 7) -> sum 9; fit_tdata=9, fit_dims=1, fit_ovf=0, fit_tvalid exactly 2 cycles after tlast beat.
2. Two dims: {10,-4} tlast_dim, then {-20,3} tlast -> dims 6 and -17; fit_tdata=17, fit_dims=2.
3. Hold fit_tready=0 for 5 cycles in EMIT -> fit_tvalid and outputs stable, prod_tready=0 throughout, and extra prod_tvalid beats are not consumed. Then raise fit_tready -> handshake, next cycle prod_tready=1.
4. ACC_WIDTH=33 variant: feed 0x7FFFFFFF three times, then tlast -> acc saturates at 2^32-1; fit_tdata=4294967295, fit_ovf=1. The next solution {1} -> fit_tdata=1, fit_ovf=0.
5. Negative saturation (ACC_WIDTH=33): 0x80000000 x3 -> acc clamps to -2^32; abs_sat gives 2^32-1, fit_ovf=1.
6. Drop ap_rst_n for 1 cycle after 2 beats of a solution -> fit_tvalid never rises for it. Then {4} tlast -> fit_tdata=4, fit_dims=1.
